arduino_knob_rx: RTL



---
 rtl/knob_link_pkg.sv | 32 +++
 rtl/arduino_knob_rx_if.sv | 25 ++
 rtl/uart_rx_byte.sv | 93 +++++++++
 rtl/arduino_knob_rx.sv | 79 +++++++
 4 files changed

// File: rtl/knob_link_pkg.sv
// Shared types and frame-field layout for the Arduino potentiometer serial link.
package knob_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  typedef enum logic {
    WAIT_HDR,
    WAIT_DATA
  } parser_state_t;

  localparam int NUM_KNOBS    = 4;
  localparam int VALUE_W      = 10;
  localparam int HDR_FLAG_BIT = 7;
  localparam int KNOB_IDX_MSB = 6;
  localparam int KNOB_IDX_LSB = 5;
  localparam int RSVD_MSB     = 4;
  localparam int RSVD_LSB     = 3;
  localparam int VAL_HI_MSB   = 2;
  localparam int VAL_HI_LSB   = 0;
  localparam int VAL_LO_MSB   = 6;
  localparam int VAL_LO_LSB   = 0;

  function automatic logic [VALUE_W-1:0] join_value(input logic [2:0] hi, input logic [6:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/arduino_knob_rx_if.sv
// Serial line in, potentiometer values and strobes out; the receiver is the slave side.
interface arduino_knob_rx_if
  import knob_link_pkg::*;
  ;
  logic               rx;
  logic [VALUE_W-1:0] user_input0;
  logic [VALUE_W-1:0] user_input1;
  logic [VALUE_W-1:0] user_input2;
  logic [VALUE_W-1:0] user_input3;
  logic [1:0]         knob_index;
  logic               value_valid;
  logic               frame_error;

  modport master (
    output rx,
    input  user_input0, user_input1, user_input2, user_input3,
    input  knob_index, value_valid, frame_error
  );

  modport slave (
    input  rx,
    output user_input0, user_input1, user_input2, user_input3,
    output knob_index, value_valid, frame_error
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: byte_done/frame_error one cycle after the mid-stop sample.
// No backpressure: each byte is offered for a single cycle.
module uart_rx_byte
  import knob_link_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frame_error
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);

  logic              rx_s1, rx_s2, rx_d;
  uart_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;

  // Edge-detect rather than level-detect so a low stop bit cannot retrigger a start.
  wire fall = rx_d & ~rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_d        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_byte     <= '0;
      byte_done   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_s1       <= rx;
      rx_s2       <= rx_s1;
      rx_d        <= rx_s2;
      byte_done   <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            cnt     <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt   <= '0;
            state <= rx_s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_W'(DIV - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_W'(DIV - 1)) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s2) begin
              byte_done <= 1'b1;
              rx_byte   <= shreg;
            end else begin
              frame_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/arduino_knob_rx.sv
// Decodes two-byte control frames into four 10-bit registers; update lands one cycle after byte_done.
// No backpressure: value_valid and frame_error are single-cycle strobes.
module arduino_knob_rx
  import knob_link_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic                clk,
  input  logic                reset,
  arduino_knob_rx_if.slave    link
);

  logic [7:0]         rx_byte;
  logic               byte_done;
  logic               byte_err;
  parser_state_t      pstate;
  logic [1:0]         hdr_idx;
  logic [2:0]         hdr_hi;
  logic [VALUE_W-1:0] knob_val [NUM_KNOBS];
  logic [1:0]         knob_index;
  logic               value_valid;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_uart (
    .clk         (clk),
    .rst         (reset),
    .rx          (link.rx),
    .rx_byte     (rx_byte),
    .byte_done   (byte_done),
    .frame_error (byte_err)
  );

  wire is_hdr   = rx_byte[HDR_FLAG_BIT];
  wire rsvd_bad = |rx_byte[RSVD_MSB:RSVD_LSB];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate      <= WAIT_HDR;
      hdr_idx     <= '0;
      hdr_hi      <= '0;
      knob_index  <= '0;
      value_valid <= 1'b0;
      for (int i = 0; i < NUM_KNOBS; i++) knob_val[i] <= '0;
    end else begin
      value_valid <= 1'b0;
      if (byte_err) begin
        pstate <= WAIT_HDR;
      end else if (byte_done) begin
        if (is_hdr) begin
          // A fresh header in WAIT_DATA simply replaces the pending one.
          if (rsvd_bad) begin
            pstate <= WAIT_HDR;
          end else begin
            hdr_idx <= rx_byte[KNOB_IDX_MSB:KNOB_IDX_LSB];
            hdr_hi  <= rx_byte[VAL_HI_MSB:VAL_HI_LSB];
            pstate  <= WAIT_DATA;
          end
        end else if (pstate == WAIT_DATA) begin
          knob_val[hdr_idx] <= join_value(hdr_hi, rx_byte[VAL_LO_MSB:VAL_LO_LSB]);
          knob_index        <= hdr_idx;
          value_valid       <= 1'b1;
          pstate            <= WAIT_HDR;
        end
      end
    end
  end

  assign link.user_input0 = knob_val[0];
  assign link.user_input1 = knob_val[1];
  assign link.user_input2 = knob_val[2];
  assign link.user_input3 = knob_val[3];
  assign link.knob_index  = knob_index;
  assign link.value_valid = value_valid;
  assign link.frame_error = byte_err;

endmodule
